pipe_hazard_ctrl: RTL and testbench

- Central stall/flush/forwarding controller for the 5-stage miniLA pipeline.
- Drives the hold (stall) and bubble (flush) controls of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Selects forwarding sources for the ID-stage operands.
- Sequences multi-cycle data-memory accesses through a small FSM with timeout.
- Keeps stall/flush performance counters for on-board debug.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 27 ++
 rtl/pipe_hazard_ctrl_fwd_unit.sv | 28 ++
 rtl/pipe_hazard_ctrl.sv | 140 ++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared encodings for the miniLA hazard controller: writeback sources,
// forwarding selects and the memory-wait FSM states.
package pipe_hazard_ctrl_pkg;

  localparam logic [2:0] WD_ALU  = 3'd0;
  localparam logic [2:0] WD_DRAM = 3'd1;
  localparam logic [2:0] WD_PC4  = 3'd2;
  localparam logic [2:0] WD_SEXT = 3'd3;

  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_EX  = 2'd1;
  localparam logic [1:0] FWD_MEM = 2'd2;
  localparam logic [1:0] FWD_WB  = 2'd3;

  typedef enum logic {
    S_RUN = 1'b0,
    S_MEM = 1'b1
  } state_t;

  // A producer only counts when it really writes a non-zero register.
  function automatic logic reg_hit(input logic [4:0] rs,
                                   input logic [4:0] rd,
                                   input logic       ena);
    return ena && (rd != 5'd0) && (rd == rs);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_fwd_unit.sv
// Operand source selection for one ID-stage register read; nearest
// writing stage wins, a load still sitting in EX is skipped.
module pipe_hazard_ctrl_fwd_unit
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic [4:0] i_rs,
  input  logic [4:0] i_ex_reg,
  input  logic       i_ex_ena,
  input  logic       i_ex_is_load,
  input  logic [4:0] i_mem_reg,
  input  logic       i_mem_ena,
  input  logic [4:0] i_wb_reg,
  input  logic       i_wb_ena,
  output logic [1:0] o_sel
);

  // Later assignments override earlier ones, so order is lowest priority first.
  always_comb begin
    o_sel = FWD_RF;
    if (reg_hit(i_rs, i_wb_reg, i_wb_ena))
      o_sel = FWD_WB;
    if (reg_hit(i_rs, i_mem_reg, i_mem_ena))
      o_sel = FWD_MEM;
    if (reg_hit(i_rs, i_ex_reg, i_ex_ena) && !i_ex_is_load)
      o_sel = FWD_EX;
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush/forwarding controller for the 5-stage miniLA pipeline with a
// memory-wait FSM (timeout release) and stall/flush performance counters.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 255
)
(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [4:0]       i_id_rs1,
  input  logic             i_id_rs1_used,
  input  logic [4:0]       i_id_rs2,
  input  logic             i_id_rs2_used,
  input  logic [4:0]       i_ex_wb_reg,
  input  logic             i_ex_wb_ena,
  input  logic [2:0]       i_ex_wD_sel,
  input  logic [4:0]       i_mem_wb_reg,
  input  logic             i_mem_wb_ena,
  input  logic [2:0]       i_mem_wD_sel,
  input  logic [4:0]       i_wb_wb_reg,
  input  logic             i_wb_wb_ena,
  input  logic             i_ex_br_taken,
  input  logic             i_mem_req,
  input  logic             i_mem_ack,
  output logic             o_stall_pc,
  output logic             o_stall_ifid,
  output logic             o_stall_idex,
  output logic             o_stall_exmem,
  output logic             o_flush_ifid,
  output logic             o_flush_idex,
  output logic             o_flush_memwb,
  output logic             o_pc_redirect,
  output logic [1:0]       o_fwd_rs1_sel,
  output logic [1:0]       o_fwd_rs2_sel,
  output logic             o_mem_timeout,
  output logic [CNT_W-1:0] o_stall_cycles,
  output logic [CNT_W-1:0] o_flush_events
);

  localparam int WCNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WCNT_W-1:0] WAIT_MAX = WCNT_W'(MEM_TIMEOUT - 1);

  state_t            r_state;
  state_t            w_next_state;
  logic [WCNT_W-1:0] r_wait_cnt;
  logic              r_mem_timeout;
  logic [CNT_W-1:0]  r_stall_cycles;
  logic [CNT_W-1:0]  r_flush_events;

  logic w_force;
  logic w_mem_wait;
  logic w_ex_load;
  logic w_load_use;
  logic w_branch;
  logic w_lu_stall;
  logic w_unused;

  // MEM forwards whatever it writes back, so its source select is not needed.
  assign w_unused = ^i_mem_wD_sel;

  assign w_force    = (r_state == S_MEM) && !i_mem_ack && (r_wait_cnt == WAIT_MAX);
  assign w_mem_wait = i_mem_req && !i_mem_ack && !w_force;
  assign w_ex_load  = i_ex_wb_ena && (i_ex_wD_sel == WD_DRAM);
  assign w_load_use = !w_mem_wait && w_ex_load &&
                      ((i_id_rs1_used && reg_hit(i_id_rs1, i_ex_wb_reg, 1'b1)) ||
                       (i_id_rs2_used && reg_hit(i_id_rs2, i_ex_wb_reg, 1'b1)));
  assign w_branch   = i_ex_br_taken && !w_mem_wait;
  // A taken branch discards the stalled younger instruction anyway.
  assign w_lu_stall = w_load_use && !w_branch;

  assign o_stall_pc    = w_mem_wait || w_lu_stall;
  assign o_stall_ifid  = w_mem_wait || w_lu_stall;
  assign o_stall_idex  = w_mem_wait;
  assign o_stall_exmem = w_mem_wait;
  assign o_flush_ifid  = w_branch;
  assign o_flush_idex  = w_branch || w_load_use;
  assign o_flush_memwb = w_mem_wait;
  assign o_pc_redirect = w_branch;

  assign o_mem_timeout  = r_mem_timeout;
  assign o_stall_cycles = r_stall_cycles;
  assign o_flush_events = r_flush_events;

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_RUN: if (i_mem_req && !i_mem_ack) w_next_state = S_MEM;
      S_MEM: if (i_mem_ack || w_force)     w_next_state = S_RUN;
      default: w_next_state = S_RUN;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state        <= S_RUN;
      r_wait_cnt     <= '0;
      r_mem_timeout  <= 1'b0;
      r_stall_cycles <= '0;
      r_flush_events <= '0;
    end else begin
      r_state       <= w_next_state;
      r_mem_timeout <= w_force;
      if (r_state == S_MEM && w_next_state == S_MEM)
        r_wait_cnt <= r_wait_cnt + WCNT_W'(1);
      else
        r_wait_cnt <= '0;
      if (o_stall_pc)
        r_stall_cycles <= r_stall_cycles + CNT_W'(1);
      if (o_pc_redirect)
        r_flush_events <= r_flush_events + CNT_W'(1);
    end
  end

  pipe_hazard_ctrl_fwd_unit u_fwd_rs1 (
    .i_rs         (i_id_rs1),
    .i_ex_reg     (i_ex_wb_reg),
    .i_ex_ena     (i_ex_wb_ena),
    .i_ex_is_load (w_ex_load),
    .i_mem_reg    (i_mem_wb_reg),
    .i_mem_ena    (i_mem_wb_ena),
    .i_wb_reg     (i_wb_wb_reg),
    .i_wb_ena     (i_wb_wb_ena),
    .o_sel        (o_fwd_rs1_sel)
  );

  pipe_hazard_ctrl_fwd_unit u_fwd_rs2 (
    .i_rs         (i_id_rs2),
    .i_ex_reg     (i_ex_wb_reg),
    .i_ex_ena     (i_ex_wb_ena),
    .i_ex_is_load (w_ex_load),
    .i_mem_reg    (i_mem_wb_reg),
    .i_mem_ena    (i_mem_wb_ena),
    .i_wb_reg     (i_wb_wb_reg),
    .i_wb_ena     (i_wb_wb_ena),
    .o_sel        (o_fwd_rs2_sel)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl; a second instance with 2-bit
// counters shares all inputs so counter wrap-around is visible.
module tb_pipe_hazard_ctrl;

  logic       clk;
  logic       rst;
  logic [4:0] id_rs1, id_rs2, ex_wb_reg, mem_wb_reg, wb_wb_reg;
  logic       id_rs1_used, id_rs2_used, ex_wb_ena, mem_wb_ena, wb_wb_ena;
  logic [2:0] ex_wD_sel, mem_wD_sel;
  logic       ex_br_taken, mem_req, mem_ack;

  logic        stall_pc, stall_ifid, stall_idex, stall_exmem;
  logic        flush_ifid, flush_idex, flush_memwb, pc_redirect;
  logic [1:0]  fwd_rs1_sel, fwd_rs2_sel;
  logic        mem_timeout;
  logic [31:0] stall_cycles, flush_events;

  logic        d2_stall_pc, d2_stall_ifid, d2_stall_idex, d2_stall_exmem;
  logic        d2_flush_ifid, d2_flush_idex, d2_flush_memwb, d2_pc_redirect;
  logic [1:0]  d2_fwd_rs1_sel, d2_fwd_rs2_sel;
  logic        d2_mem_timeout;
  logic [1:0]  d2_stall_cycles, d2_flush_events;

  logic [7:0] ctl;
  int testsRun;
  int testsFailed;

  // Packed view: {stall_pc, stall_ifid, stall_idex, stall_exmem,
  //               flush_ifid, flush_idex, flush_memwb, pc_redirect}
  assign ctl = {stall_pc, stall_ifid, stall_idex, stall_exmem,
                flush_ifid, flush_idex, flush_memwb, pc_redirect};

  pipe_hazard_ctrl #(.CNT_W(32), .MEM_TIMEOUT(4)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_id_rs1(id_rs1), .i_id_rs1_used(id_rs1_used),
    .i_id_rs2(id_rs2), .i_id_rs2_used(id_rs2_used),
    .i_ex_wb_reg(ex_wb_reg), .i_ex_wb_ena(ex_wb_ena), .i_ex_wD_sel(ex_wD_sel),
    .i_mem_wb_reg(mem_wb_reg), .i_mem_wb_ena(mem_wb_ena), .i_mem_wD_sel(mem_wD_sel),
    .i_wb_wb_reg(wb_wb_reg), .i_wb_wb_ena(wb_wb_ena),
    .i_ex_br_taken(ex_br_taken), .i_mem_req(mem_req), .i_mem_ack(mem_ack),
    .o_stall_pc(stall_pc), .o_stall_ifid(stall_ifid),
    .o_stall_idex(stall_idex), .o_stall_exmem(stall_exmem),
    .o_flush_ifid(flush_ifid), .o_flush_idex(flush_idex),
    .o_flush_memwb(flush_memwb), .o_pc_redirect(pc_redirect),
    .o_fwd_rs1_sel(fwd_rs1_sel), .o_fwd_rs2_sel(fwd_rs2_sel),
    .o_mem_timeout(mem_timeout),
    .o_stall_cycles(stall_cycles), .o_flush_events(flush_events)
  );

  pipe_hazard_ctrl #(.CNT_W(2), .MEM_TIMEOUT(4)) dut2 (
    .i_clk(clk), .i_rst(rst),
    .i_id_rs1(id_rs1), .i_id_rs1_used(id_rs1_used),
    .i_id_rs2(id_rs2), .i_id_rs2_used(id_rs2_used),
    .i_ex_wb_reg(ex_wb_reg), .i_ex_wb_ena(ex_wb_ena), .i_ex_wD_sel(ex_wD_sel),
    .i_mem_wb_reg(mem_wb_reg), .i_mem_wb_ena(mem_wb_ena), .i_mem_wD_sel(mem_wD_sel),
    .i_wb_wb_reg(wb_wb_reg), .i_wb_wb_ena(wb_wb_ena),
    .i_ex_br_taken(ex_br_taken), .i_mem_req(mem_req), .i_mem_ack(mem_ack),
    .o_stall_pc(d2_stall_pc), .o_stall_ifid(d2_stall_ifid),
    .o_stall_idex(d2_stall_idex), .o_stall_exmem(d2_stall_exmem),
    .o_flush_ifid(d2_flush_ifid), .o_flush_idex(d2_flush_idex),
    .o_flush_memwb(d2_flush_memwb), .o_pc_redirect(d2_pc_redirect),
    .o_fwd_rs1_sel(d2_fwd_rs1_sel), .o_fwd_rs2_sel(d2_fwd_rs2_sel),
    .o_mem_timeout(d2_mem_timeout),
    .o_stall_cycles(d2_stall_cycles), .o_flush_events(d2_flush_events)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clearInputs();
    id_rs1 = 5'd0; id_rs1_used = 1'b0; id_rs2 = 5'd0; id_rs2_used = 1'b0;
    ex_wb_reg = 5'd0; ex_wb_ena = 1'b0; ex_wD_sel = 3'd0;
    mem_wb_reg = 5'd0; mem_wb_ena = 1'b0; mem_wD_sel = 3'd0;
    wb_wb_reg = 5'd0; wb_wb_ena = 1'b0;
    ex_br_taken = 1'b0; mem_req = 1'b0; mem_ack = 1'b0;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clearInputs();
    rst = 1'b1;
    nextCycle();
    rst = 1'b0;
    #1;
    testsRun++; if (ctl !== 8'b0000_0000) begin testsFailed++; $display("[TB] FAIL reset_ctl: got %b expected %b", ctl, 8'b0000_0000); end
    testsRun++; if (stall_cycles !== 32'd0 || flush_events !== 32'd0) begin testsFailed++; $display("[TB] FAIL reset_counters: got %0d/%0d expected 0/0", stall_cycles, flush_events); end
    testsRun++; if (mem_timeout !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_timeout: got %b expected 0", mem_timeout); end
    testsRun++; if (fwd_rs1_sel !== 2'd0 || fwd_rs2_sel !== 2'd0) begin testsFailed++; $display("[TB] FAIL reset_fwd: got %0d/%0d expected 0/0", fwd_rs1_sel, fwd_rs2_sel); end
    nextCycle();
  endtask

  task automatic test_load_use();
    clearInputs();
    ex_wb_reg = 5'd5; ex_wb_ena = 1'b1; ex_wD_sel = 3'd1;
    id_rs1 = 5'd5; id_rs1_used = 1'b1;
    #1;
    testsRun++; if (ctl !== 8'b1100_0100) begin testsFailed++; $display("[TB] FAIL loaduse_ctl: got %b expected %b", ctl, 8'b1100_0100); end
    testsRun++; if (fwd_rs1_sel !== 2'd0) begin testsFailed++; $display("[TB] FAIL loaduse_no_ex_fwd: got %0d expected 0", fwd_rs1_sel); end
    nextCycle();
    testsRun++; if (stall_cycles !== 32'd1) begin testsFailed++; $display("[TB] FAIL loaduse_count: got %0d expected 1", stall_cycles); end
    ex_wb_reg = 5'd0; ex_wb_ena = 1'b0; ex_wD_sel = 3'd0;
    mem_wb_reg = 5'd5; mem_wb_ena = 1'b1; mem_wD_sel = 3'd1;
    #1;
    testsRun++; if (ctl !== 8'b0000_0000) begin testsFailed++; $display("[TB] FAIL loaduse_release_ctl: got %b expected %b", ctl, 8'b0000_0000); end
    testsRun++; if (fwd_rs1_sel !== 2'd2) begin testsFailed++; $display("[TB] FAIL loaduse_mem_fwd: got %0d expected 2", fwd_rs1_sel); end
    nextCycle();
    clearInputs();
    ex_wb_reg = 5'd0; ex_wb_ena = 1'b1; ex_wD_sel = 3'd1;
    id_rs1 = 5'd0; id_rs1_used = 1'b1;
    #1;
    testsRun++; if (ctl !== 8'b0000_0000) begin testsFailed++; $display("[TB] FAIL loaduse_r0: got %b expected %b", ctl, 8'b0000_0000); end
    ex_wb_reg = 5'd6; id_rs2 = 5'd6; id_rs2_used = 1'b0; id_rs1 = 5'd5;
    #1;
    testsRun++; if (ctl !== 8'b0000_0000) begin testsFailed++; $display("[TB] FAIL loaduse_unused_rs: got %b expected %b", ctl, 8'b0000_0000); end
    nextCycle();
    testsRun++; if (stall_cycles !== 32'd1 || d2_stall_cycles !== 2'd1) begin testsFailed++; $display("[TB] FAIL loaduse_count_hold: got %0d/%0d expected 1/1", stall_cycles, d2_stall_cycles); end
  endtask

  task automatic test_forwarding();
    clearInputs();
    ex_wb_reg = 5'd3; ex_wb_ena = 1'b1;
    mem_wb_reg = 5'd3; mem_wb_ena = 1'b1;
    wb_wb_reg = 5'd3; wb_wb_ena = 1'b1;
    id_rs2 = 5'd3; id_rs2_used = 1'b1;
    #1;
    testsRun++; if (fwd_rs2_sel !== 2'd1) begin testsFailed++; $display("[TB] FAIL fwd_ex: got %0d expected 1", fwd_rs2_sel); end
    ex_wb_reg = 5'd0; mem_wb_reg = 5'd0; wb_wb_reg = 5'd0; id_rs2 = 5'd0;
    #1;
    testsRun++; if (fwd_rs2_sel !== 2'd0) begin testsFailed++; $display("[TB] FAIL fwd_r0: got %0d expected 0", fwd_rs2_sel); end
    ex_wb_reg = 5'd3; ex_wb_ena = 1'b0; mem_wb_reg = 5'd3; wb_wb_reg = 5'd3; id_rs2 = 5'd3;
    #1;
    testsRun++; if (fwd_rs2_sel !== 2'd2) begin testsFailed++; $display("[TB] FAIL fwd_ex_disabled: got %0d expected 2", fwd_rs2_sel); end
    ex_wb_reg = 5'd9; ex_wb_ena = 1'b1; mem_wb_reg = 5'd8; wb_wb_reg = 5'd3;
    id_rs1 = 5'd8; id_rs1_used = 1'b1;
    #1;
    testsRun++; if (fwd_rs2_sel !== 2'd3 || fwd_rs1_sel !== 2'd2) begin testsFailed++; $display("[TB] FAIL fwd_wb_mem: got %0d/%0d expected 3/2", fwd_rs2_sel, fwd_rs1_sel); end
    nextCycle();
    ex_wb_reg = 5'd3; ex_wD_sel = 3'd1; mem_wb_reg = 5'd3; id_rs1 = 5'd0;
    #1;
    testsRun++; if (fwd_rs2_sel !== 2'd2 || ctl !== 8'b1100_0100) begin testsFailed++; $display("[TB] FAIL fwd_skip_ex_load: got sel %0d ctl %b expected 2 %b", fwd_rs2_sel, ctl, 8'b1100_0100); end
    nextCycle();
    testsRun++; if (stall_cycles !== 32'd2) begin testsFailed++; $display("[TB] FAIL fwd_count: got %0d expected 2", stall_cycles); end
  endtask

  task automatic test_branch_over_load_use();
    clearInputs();
    ex_wb_reg = 5'd5; ex_wb_ena = 1'b1; ex_wD_sel = 3'd1;
    id_rs1 = 5'd5; id_rs1_used = 1'b1; ex_br_taken = 1'b1;
    #1;
    testsRun++; if (ctl !== 8'b0000_1101) begin testsFailed++; $display("[TB] FAIL branch_ctl: got %b expected %b", ctl, 8'b0000_1101); end
    nextCycle();
    testsRun++; if (flush_events !== 32'd1 || stall_cycles !== 32'd2) begin testsFailed++; $display("[TB] FAIL branch_counts: got %0d/%0d expected 1/2", flush_events, stall_cycles); end
  endtask

  task automatic test_mem_ack();
    clearInputs();
    mem_req = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      testsRun++; if (ctl !== 8'b1111_0010) begin testsFailed++; $display("[TB] FAIL memack_wait%0d: got %b expected %b", c, ctl, 8'b1111_0010); end
      nextCycle();
    end
    mem_ack = 1'b1;
    #1;
    testsRun++; if (ctl !== 8'b0000_0000) begin testsFailed++; $display("[TB] FAIL memack_release: got %b expected %b", ctl, 8'b0000_0000); end
    nextCycle();
    #1;
    testsRun++; if (ctl !== 8'b0000_0000) begin testsFailed++; $display("[TB] FAIL memack_zero_wait: got %b expected %b", ctl, 8'b0000_0000); end
    nextCycle();
    clearInputs();
    for (int c = 0; c < 5; c++) begin
      #1;
      testsRun++; if (mem_timeout !== 1'b0) begin testsFailed++; $display("[TB] FAIL memack_no_timeout%0d: got %b expected 0", c, mem_timeout); end
      nextCycle();
    end
    testsRun++; if (stall_cycles !== 32'd5) begin testsFailed++; $display("[TB] FAIL memack_count: got %0d expected 5", stall_cycles); end
  endtask

  task automatic test_timeout();
    clearInputs();
    mem_req = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      testsRun++; if (ctl !== 8'b1111_0010) begin testsFailed++; $display("[TB] FAIL timeout_wait%0d: got %b expected %b", c, ctl, 8'b1111_0010); end
      nextCycle();
    end
    #1;
    testsRun++; if (ctl !== 8'b0000_0000 || mem_timeout !== 1'b0) begin testsFailed++; $display("[TB] FAIL timeout_release: got %b/%b expected %b/0", ctl, mem_timeout, 8'b0000_0000); end
    nextCycle();
    mem_req = 1'b0;
    #1;
    testsRun++; if (mem_timeout !== 1'b1) begin testsFailed++; $display("[TB] FAIL timeout_pulse: got %b expected 1", mem_timeout); end
    nextCycle();
    #1;
    testsRun++; if (mem_timeout !== 1'b0) begin testsFailed++; $display("[TB] FAIL timeout_pulse_end: got %b expected 0", mem_timeout); end
    testsRun++; if (stall_cycles !== 32'd9 || d2_stall_cycles !== 2'd1) begin testsFailed++; $display("[TB] FAIL timeout_count: got %0d/%0d expected 9/1", stall_cycles, d2_stall_cycles); end
    nextCycle();
  endtask

  task automatic test_branch_during_wait();
    clearInputs();
    mem_req = 1'b1; ex_br_taken = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #1;
      testsRun++; if (ctl !== 8'b1111_0010) begin testsFailed++; $display("[TB] FAIL brwait_hold%0d: got %b expected %b", c, ctl, 8'b1111_0010); end
      nextCycle();
    end
    mem_ack = 1'b1;
    #1;
    testsRun++; if (ctl !== 8'b0000_1101) begin testsFailed++; $display("[TB] FAIL brwait_release: got %b expected %b", ctl, 8'b0000_1101); end
    nextCycle();
    testsRun++; if (stall_cycles !== 32'd11 || flush_events !== 32'd2) begin testsFailed++; $display("[TB] FAIL brwait_counts: got %0d/%0d expected 11/2", stall_cycles, flush_events); end
    testsRun++; if (d2_stall_cycles !== 2'd3 || d2_flush_events !== 2'd2) begin testsFailed++; $display("[TB] FAIL brwait_counts_wrap: got %0d/%0d expected 3/2", d2_stall_cycles, d2_flush_events); end
  endtask

  task automatic test_reset_mid_wait();
    clearInputs();
    mem_req = 1'b1;
    #1;
    testsRun++; if (ctl !== 8'b1111_0010) begin testsFailed++; $display("[TB] FAIL rstwait_stall: got %b expected %b", ctl, 8'b1111_0010); end
    nextCycle();
    rst = 1'b1;
    nextCycle();
    rst = 1'b0;
    mem_req = 1'b0;
    #1;
    testsRun++; if (ctl !== 8'b0000_0000 || mem_timeout !== 1'b0) begin testsFailed++; $display("[TB] FAIL rstwait_outputs: got %b/%b expected %b/0", ctl, mem_timeout, 8'b0000_0000); end
    testsRun++; if (stall_cycles !== 32'd0 || flush_events !== 32'd0 || d2_stall_cycles !== 2'd0) begin testsFailed++; $display("[TB] FAIL rstwait_counters: got %0d/%0d/%0d expected 0/0/0", stall_cycles, flush_events, d2_stall_cycles); end
    nextCycle();
  endtask

  initial begin
    testsRun = 0;
    testsFailed = 0;
    rst = 1'b1;
    clearInputs();
    test_reset();
    test_load_use();
    test_forwarding();
    test_branch_over_load_use();
    test_mem_ack();
    test_timeout();
    test_branch_during_wait();
    test_reset_mid_wait();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
